// File: rtl/booth_radix4_mul_iter.sv
// Iterative radix-4 Booth multiplier with valid/ready handshakes, flush and clock enable.
// One operation in flight; one recoded digit retired per enabled cycle.
module booth_radix4_mul_iter #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clk_en_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [XLEN-1:0]   op_a_i,
    input  logic [XLEN-1:0]   op_b_i,
    input  logic [1:0]        op_sel_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [XLEN-1:0]   result_o,
    output logic [2*XLEN-1:0] product_o,
    output logic              busy_o
);

    localparam int unsigned STEPS = (XLEN + 2) / 2;
    localparam int unsigned CNT_W = $clog2(STEPS);
    localparam int unsigned EW    = XLEN + 2;
    localparam int unsigned PW    = XLEN + 3;

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [1:0]          sel_q;
    logic [EW-1:0]       mcand_q;
    logic [EW-1:0]       mplier_q;
    logic                lsb_q;
    logic [PW-1:0]       pp_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [XLEN-1:0]     res_q;

    logic                accept;
    logic                last_step;
    logic                sign_a, sign_b;
    logic [EW-1:0]       a_ext, b_ext;
    logic [PW-1:0]       mcand_x, addend, sum;
    logic [PW-1:0]       pp_nxt;
    logic [EW-1:0]       mp_nxt;
    logic [2*XLEN-1:0]   prod_nxt;
    logic [XLEN-1:0]     res_nxt;

    assign accept    = clk_en_i && valid_i && ready_o;
    assign last_step = (state_q == COMPUTE) && (cnt_q == CNT_W'(STEPS - 1));

    assign sign_a = (op_sel_i != 2'b11);
    assign sign_b = !op_sel_i[1];
    assign a_ext  = {{2{sign_a & op_a_i[XLEN-1]}}, op_a_i};
    assign b_ext  = {{2{sign_b & op_b_i[XLEN-1]}}, op_b_i};

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; flush acts regardless of clock enable
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (clk_en_i) begin
            unique case (state_q)
                IDLE:    if (valid_i)   state_d = COMPUTE;
                COMPUTE: if (last_step) state_d = DONE;
                DONE:    if (ready_i)   state_d = IDLE;
                default:                state_d = IDLE;
            endcase
        end
    end

    // Output logic
    always_comb begin
        ready_o   = (state_q == IDLE) && !flush_i;
        valid_o   = (state_q == DONE);
        busy_o    = (state_q != IDLE);
        result_o  = res_q;
        product_o = prod_q;
    end

    // Booth digit from {A[1:0], L}; the step then shifts {P, A, L} right by two
    always_comb begin
        mcand_x = {mcand_q[EW-1], mcand_q};
        addend  = '0;
        unique case ({mplier_q[1:0], lsb_q})
            3'b001, 3'b010: addend = mcand_x;
            3'b011:         addend = {mcand_q, 1'b0};
            3'b100:         addend = -{mcand_q, 1'b0};
            3'b101, 3'b110: addend = -mcand_x;
            default:        addend = '0;
        endcase
        sum      = pp_q + addend;
        pp_nxt   = {{2{sum[PW-1]}}, sum[PW-1:2]};
        mp_nxt   = {sum[1:0], mplier_q[EW-1:2]};
        prod_nxt = {pp_nxt[XLEN-3:0], mp_nxt};
        res_nxt  = (sel_q == 2'b00) ? prod_nxt[XLEN-1:0] : prod_nxt[2*XLEN-1:XLEN];
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q    <= '0;
            sel_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            lsb_q    <= 1'b0;
            pp_q     <= '0;
            prod_q   <= '0;
            res_q    <= '0;
        end else if (flush_i) begin
            cnt_q <= '0;
        end else if (clk_en_i) begin
            if (accept) begin
                sel_q    <= op_sel_i;
                mcand_q  <= a_ext;
                mplier_q <= b_ext;
                lsb_q    <= 1'b0;
                pp_q     <= '0;
                cnt_q    <= '0;
            end else if (state_q == COMPUTE) begin
                pp_q     <= pp_nxt;
                mplier_q <= mp_nxt;
                lsb_q    <= mplier_q[1];
                cnt_q    <= cnt_q + CNT_W'(1);
                if (last_step) begin
                    prod_q <= prod_nxt;
                    res_q  <= res_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_radix4_mul_iter.sv
// Directed and random checks of booth_radix4_mul_iter at XLEN = 32 and XLEN = 8.
module tb_booth_radix4_mul_iter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        flush = 1'b0;

    logic        v32 = 1'b0, rdy32, vo32, ri32 = 1'b0, busy32;
    logic [31:0] a32 = '0, b32 = '0, res32;
    logic [1:0]  sel32 = '0;
    logic [63:0] prod32;

    logic        v8 = 1'b0, rdy8, vo8, ri8 = 1'b0, busy8;
    logic [7:0]  a8 = '0, b8 = '0, res8;
    logic [1:0]  sel8 = '0;
    logic [15:0] prod8;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    booth_radix4_mul_iter #(.XLEN(32)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .flush_i(flush),
        .valid_i(v32), .ready_o(rdy32), .op_a_i(a32), .op_b_i(b32), .op_sel_i(sel32),
        .valid_o(vo32), .ready_i(ri32), .result_o(res32), .product_o(prod32), .busy_o(busy32)
    );

    booth_radix4_mul_iter #(.XLEN(8)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .clk_en_i(clk_en), .flush_i(flush),
        .valid_i(v8), .ready_o(rdy8), .op_a_i(a8), .op_b_i(b8), .op_sel_i(sel8),
        .valid_o(vo8), .ready_i(ri8), .result_o(res8), .product_o(prod8), .busy_o(busy8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] ref32(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be;
        ae = (sel != 2'b11 && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        be = (!sel[1] && b[31])      ? {32'hFFFF_FFFF, b} : {32'h0, b};
        return ae * be;
    endfunction

    function automatic logic [15:0] ref8(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] ae, be;
        ae = (sel != 2'b11 && a[7]) ? {8'hFF, a} : {8'h0, a};
        be = (!sel[1] && b[7])      ? {8'hFF, b} : {8'h0, b};
        return ae * be;
    endfunction

    // Latency counts edges from the accept edge (inclusive) to valid_o high.
    task automatic run32(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] b,
                         input int stall_at, input bit hold,
                         output logic [63:0] prod, output logic [31:0] res, output int lat);
        int guard = 0;
        while (!rdy32 && guard < 50) begin tick(); guard++; end
        sel32 = sel; a32 = a; b32 = b; v32 = 1'b1;
        tick();
        v32 = 1'b0;
        lat = 1;
        while (!vo32 && lat < 200) begin
            if (lat == stall_at) begin
                clk_en = 1'b0;
                repeat (3) begin tick(); lat++; end
                clk_en = 1'b1;
            end else begin
                tick(); lat++;
            end
        end
        if (!vo32) check("valid32_bound", 64'(vo32), 64'd1);
        prod = prod32;
        res  = res32;
        if (!hold) begin
            ri32 = 1'b1; tick(); ri32 = 1'b0;
        end
    endtask

    task automatic run8(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] prod, output logic [7:0] res, output int lat);
        int guard = 0;
        while (!rdy8 && guard < 50) begin tick(); guard++; end
        sel8 = sel; a8 = a; b8 = b; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        lat = 1;
        while (!vo8 && lat < 100) begin tick(); lat++; end
        if (!vo8) check("valid8_bound", 64'(vo8), 64'd1);
        prod = prod8;
        res  = res8;
        ri8 = 1'b1; tick(); ri8 = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] p;
        logic [31:0] r;
        logic [15:0] p8;
        logic [7:0]  r8;
        logic [31:0] held;
        logic [1:0]  s;
        logic [31:0] ra, rb;
        logic [63:0] e;
        logic [15:0] e8;
        int          lat;
        int          seen;

        repeat (3) tick();
        check("rst_ready",  64'(rdy32),  64'd1);
        check("rst_valid",  64'(vo32),   64'd0);
        check("rst_busy",   64'(busy32), 64'd0);
        check("rst_result", 64'(res32),  64'd0);
        check("rst_prod",   prod32,      64'd0);
        check("rst_ready8", 64'(rdy8),   64'd1);
        rst_n = 1'b1;
        tick();

        run32(2'b00, 32'd7, 32'hFFFF_FFFD, -1, 1'b0, p, r, lat);
        check("mul_res",  64'(r), 64'hFFFF_FFEB);
        check("mul_prod", p,      64'hFFFF_FFFF_FFFF_FFEB);
        check("mul_lat",  64'(lat), 64'd18);

        run32(2'b01, 32'h8000_0000, 32'h8000_0000, -1, 1'b0, p, r, lat);
        check("mulh_res", 64'(r), 64'h4000_0000);

        run32(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, p, r, lat);
        check("mulhu_res", 64'(r),            64'hFFFF_FFFE);
        check("mulhu_lo",  64'(p[31:0]),      64'h0000_0001);

        run32(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, p, r, lat);
        check("mulhsu_prod", p,      64'hFFFF_FFFF_0000_0001);
        check("mulhsu_res",  64'(r), 64'hFFFF_FFFF);

        // Backpressure: result holds while ready_i stays low
        run32(2'b00, 32'd1000, 32'd1000, -1, 1'b1, p, r, lat);
        held = res32;
        check("bp_first", 64'(held), 64'd1_000_000);
        repeat (5) begin
            tick();
            check("bp_valid",  64'(vo32),  64'd1);
            check("bp_ready",  64'(rdy32), 64'd0);
            check("bp_stable", 64'(res32), 64'(held));
        end
        ri32 = 1'b1; tick(); ri32 = 1'b0;
        check("retire_valid", 64'(vo32),  64'd0);
        check("retire_ready", 64'(rdy32), 64'd1);

        run32(2'b00, 32'd12, 32'd11, 5, 1'b0, p, r, lat);
        check("stall_res", 64'(r),   64'd132);
        check("stall_lat", 64'(lat), 64'd21);

        // Flush in the middle of COMPUTE
        sel32 = 2'b00; a32 = 32'd9; b32 = 32'd9; v32 = 1'b1;
        tick(); v32 = 1'b0;
        repeat (5) tick();
        flush = 1'b1; tick(); flush = 1'b0;
        check("flush_busy",  64'(busy32), 64'd0);
        check("flush_valid", 64'(vo32),   64'd0);
        seen = 0;
        repeat (25) begin tick(); if (vo32) seen++; end
        check("flush_no_valid", 64'(seen), 64'd0);
        run32(2'b00, 32'd3, 32'd5, -1, 1'b0, p, r, lat);
        check("after_flush_res", 64'(r),   64'd15);
        check("after_flush_lat", 64'(lat), 64'd18);

        // Flush in IDLE blocks acceptance
        flush = 1'b1; v32 = 1'b1; #1;
        check("flush_idle_ready", 64'(rdy32), 64'd0);
        tick(); flush = 1'b0; v32 = 1'b0;
        check("flush_idle_busy", 64'(busy32), 64'd0);

        // Flush in DONE drops the result even with ready_i high
        run32(2'b00, 32'd2, 32'd2, -1, 1'b1, p, r, lat);
        check("done_hold_valid", 64'(vo32), 64'd1);
        flush = 1'b1; ri32 = 1'b1; tick(); flush = 1'b0; ri32 = 1'b0;
        check("flush_done_valid", 64'(vo32),   64'd0);
        check("flush_done_busy",  64'(busy32), 64'd0);

        // Reset in the middle of COMPUTE
        sel32 = 2'b00; a32 = 32'd77; b32 = 32'd77; v32 = 1'b1;
        tick(); v32 = 1'b0;
        repeat (6) tick();
        rst_n = 1'b0; tick();
        check("mrst_ready",  64'(rdy32),  64'd1);
        check("mrst_valid",  64'(vo32),   64'd0);
        check("mrst_busy",   64'(busy32), 64'd0);
        check("mrst_result", 64'(res32),  64'd0);
        check("mrst_prod",   prod32,      64'd0);
        rst_n = 1'b1; tick();

        run8(2'b01, 8'h80, 8'h80, p8, r8, lat);
        check("mulh8_res", 64'(r8),  64'h40);
        check("mul8_lat",  64'(lat), 64'd6);
        run8(2'b10, 8'hFF, 8'hFF, p8, r8, lat);
        check("mulhsu8_prod", 64'(p8), 64'hFF01);

        for (int i = 0; i < 500; i++) begin
            s = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
            e = ref32(s, ra, rb);
            run32(s, ra, rb, -1, 1'b0, p, r, lat);
            check("rnd32_prod", p, e);
            check("rnd32_res", 64'(r), (s == 2'b00) ? 64'(e[31:0]) : 64'(e[63:32]));
        end
        for (int i = 0; i < 500; i++) begin
            s = 2'($urandom_range(0, 3)); ra = $urandom; rb = $urandom;
            e8 = ref8(s, ra[7:0], rb[7:0]);
            run8(s, ra[7:0], rb[7:0], p8, r8, lat);
            check("rnd8_prod", 64'(p8), 64'(e8));
            check("rnd8_res", 64'(r8), (s == 2'b00) ? 64'(e8[7:0]) : 64'(e8[15:8]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
